// File: rtl/subtractor_64bit_seq_if.sv
// ============================================================================
// Module      : subtractor_64bit_seq_if
// Description : Valid/ready operand and result bundle for the multi-cycle
//               subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface subtractor_64bit_seq_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] inp1;
    logic [N-1:0] inp2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    modport master (
        output in_valid, inp1, inp2, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, inp1, inp2, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

`default_nettype wire

// File: rtl/subtractor_64bit_seq.sv
// ============================================================================
// Module      : subtractor_64bit_seq
// Description : Multi-cycle N-bit subtractor on one N/2-bit add slice, low
//               half then high half, with valid/ready on both sides.
//               Optional macro SUBTRACTOR_SATURATE_EN saturates diff on
//               signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtractor_64bit_seq #(
    parameter int N = 64
) (
    input  wire logic            clk,
    input  wire logic            rst,
    subtractor_64bit_seq_if.slave bus
);
    localparam int M = N / 2;

    if ((N % 2) != 0 || N < 4) begin : g_bad_width
        $error("subtractor_64bit_seq: N must be even and >= 4");
    end

`ifdef SUBTRACTOR_SATURATE_EN
    localparam logic [N-1:0] C_MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] C_MIN_NEG = {1'b1, {(N-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_c;
    logic [M-1:0] r_lo;
    logic [N-1:0] r_diff;
    logic         r_bout;
    logic         r_ovf;

    logic [M-1:0] w_slice_a;
    logic [M-1:0] w_slice_b;
    logic         w_slice_cin;
    logic [M:0]   w_slice_sum;
    logic         w_ovf;
    logic [N-1:0] w_diff_hi;

    // The single add slice; its operands are steered by state and zeroed
    // when no half is being computed.
    always_comb begin
        w_slice_a   = '0;
        w_slice_b   = '0;
        w_slice_cin = 1'b0;
        case (r_state)
            LOW: begin
                w_slice_a   = r_a[M-1:0];
                w_slice_b   = ~r_b[M-1:0];
                w_slice_cin = r_c;
            end
            HIGH: begin
                w_slice_a   = r_a[N-1:M];
                w_slice_b   = ~r_b[N-1:M];
                w_slice_cin = r_c;
            end
            default: ;
        endcase
    end

    assign w_slice_sum = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {{M{1'b0}}, w_slice_cin};

    assign w_ovf = (r_a[N-1] != r_b[N-1]) && (w_slice_sum[M-1] != r_a[N-1]);

    always_comb begin
        w_diff_hi = {w_slice_sum[M-1:0], r_lo};
`ifdef SUBTRACTOR_SATURATE_EN
        if (w_ovf) begin
            w_diff_hi = r_a[N-1] ? C_MIN_NEG : C_MAX_POS;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next_state = LOW;
            LOW:     w_next_state = HIGH;
            HIGH:    w_next_state = DONE;
            DONE:    if (bus.out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_lo   <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a <= bus.inp1;
                        r_b <= bus.inp2;
                        r_c <= 1'b1;
                    end
                end
                LOW: begin
                    r_lo <= w_slice_sum[M-1:0];
                    r_c  <= w_slice_sum[M];
                end
                HIGH: begin
                    r_diff <= w_diff_hi;
                    r_bout <= ~w_slice_sum[M];
                    r_ovf  <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: doc/subtractor_64bit_seq.md
Name: subtractor_64bit_seq

Overview:
- Multi-cycle N-bit two's-complement subtractor (diff = inp1 - inp2) built on one internal N/2-bit add slice.
- Each operation runs low half then high half, computed as A + ~B + carry, with the carry chained through a register.
- Companion to the multi-cycle adder in the arithmetic datapath. Adds a valid/ready handshake on both input and output so it can sit between pipeline stages.

Parameters:
- N, 64, operand/result width; must be even and >= 4
- M, N/2 (localparam), width of the internal add slice

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands on inp1/inp2 are valid
- in_ready  output  1  block can accept a new operation
- inp1  input  N  minuend, signed
- inp2  input  N  subtrahend, signed
- out_valid  output  1  diff/bout/ovf are valid
- out_ready  input  1  downstream accepts result
- diff  output  N  inp1 - inp2, signed, modulo 2^N (or saturated, see Optional Feature)
- bout  output  1  unsigned borrow: 1 iff inp1 < inp2 as unsigned values
- ovf  output  1  signed overflow of the subtraction

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; diff=0, bout=0, ovf=0, out_valid=0; operand and carry registers cleared. Reset overrides every other condition in any state, including mid-operation; a partial result is discarded and never presented.
- in_ready = 1 only in IDLE (combinational from state). out_valid = 1 only in DONE.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - If in_valid=1, capture inp1/inp2 into operand registers a_r/b_r, set carry register c_r=1, go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - Slice computes {c, s} = a_r[M-1:0] + ~b_r[M-1:0] + c_r.
  - Register s into lo_r and c into c_r; go to HIGH.
- HIGH:
  - Slice computes {c, s} = a_r[N-1:M] + ~b_r[N-1:M] + c_r.
  - Register diff={s, lo_r} and bout = ~c.
  - Register ovf = (a_r[N-1] != b_r[N-1]) && (s[M-1] != a_r[N-1]).
  - Go to DONE.
- DONE:
  - Hold diff/bout/ovf stable.
  - If out_ready=1, go to IDLE; otherwise stay in DONE (backpressure, unbounded).
  - A new request is not accepted in the cycle out_ready is seen.
- Latency: with the accepting edge at cycle 0, out_valid=1 after the edge at cycle 2 (sampled at edge 3). Minimum issue interval 4 cycles.
- Operand isolation: inp1/inp2 are sampled only on the accepting edge. Later changes do not affect the result in flight.
- Outputs diff/bout/ovf keep their last value after leaving DONE, until the next HIGH or reset. Consumers qualify them with out_valid only.
- Only one slice instance. Its A/B/cin inputs are muxed by state and driven to 0 in IDLE/DONE. No additional N-bit adder is allowed.
- Fully synchronous; no latches; every combinational output is assigned in every state.

Optional Feature:
- Macro: SUBTRACTOR_SATURATE_EN
- Defined: when the signed overflow condition is true in HIGH, diff is registered as the saturated value instead of the wrapped difference:
  - 0111...1 (max positive) if a_r[N-1]=0
  - 1000...0 (min negative) if a_r[N-1]=1
  - ovf is still reported as 1; bout is unchanged (it is computed from the unsaturated result).
- Not defined: diff is always the wrapped modulo-2^N difference.
- Latency, handshake and ports are identical in both builds.

Test Plan:
- Reset mid-op: accept (100, 1), assert rst in HIGH state -> next cycle state IDLE, out_valid=0, diff=0, in_ready=1; no result is ever presented for that operation.
- Basic with low-half borrow: inp1=64'h0000_0001_0000_0000, inp2=1, out_ready=1 -> out_valid=1 exactly at edge 3 after accept; diff=64'h0000_0000_FFFF_FFFF, bout=0, ovf=0.
- Unsigned borrow/negative: inp1=5, inp2=7 -> diff=64'hFFFF_FFFF_FFFF_FFFE (-2), bout=1, ovf=0.
- Signed overflow: inp1=64'h8000_0000_0000_0000, inp2=1 -> ovf=1, bout=0:
  - Without macro: diff=64'h7FFF_FFFF_FFFF_FFFF (wrapped).
  - With SUBTRACTOR_SATURATE_EN: diff=64'h8000_0000_0000_0000 (saturated min).
- Backpressure and isolation: (10, 3) with out_ready=0 for 5 cycles, inp1/inp2 changed after accept, in_valid held high -> diff=7 held stable with out_valid=1; in_ready=0 throughout; next operation accepted only after out_ready=1 and return to IDLE.
- Back-to-back stream: 20 random operand pairs with in_valid always 1, out_ready always 1 -> one result every 4 cycles, each diff/bout/ovf matching the reference model.
